hf_mul_result_fifo: RTL and testbench

//  Downstream stage of the combinational FP16 multiplier. Captures each 16-bit

---
 rtl/hf_mul_result_fifo.sv | 168 ++++++++++++++++
 tb/tb_hf_mul_result_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/hf_mul_result_fifo.sv
// Result buffer behind the FP16 multiplier: classifies and queues products, tracks sticky flags and NaN count.
// Optional build macro HFMUL_FTZ_EN flushes subnormal products to signed zero at push time.
module hf_mul_result_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int NCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [15:0]       in_res_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [15:0]       out_res_o,
   output logic [3:0]        out_flags_o,
   output logic [ADDR_W:0]   count_o,
   output logic [3:0]        sticky_o,
   input  logic              clr_sticky_i,
   output logic [NCNT_W-1:0] nan_cnt_o
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [NCNT_W-1:0] NCNT_MAX = {NCNT_W{1'b1}};

   // Flag order is {nan, inf, zero, sub}.
   function automatic logic [3:0] classify(input logic [15:0] res);
      logic [4:0] e;
      logic [9:0] f;
      logic [3:0] fl;
      e = res[14:10];
      f = res[9:0];
      fl = 4'b0000;
      fl[3] = (e == 5'h1F) && (f != 10'd0);
      fl[2] = (e == 5'h1F) && (f == 10'd0);
      fl[1] = (e == 5'h00) && (f == 10'd0);
      fl[0] = (e == 5'h00) && (f != 10'd0);
      return fl;
   endfunction

   logic [19:0]       mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [15:0]       out_res_q, out_res_d;
   logic [3:0]        out_flags_q, out_flags_d;
   logic [3:0]        sticky_q, sticky_d;
   logic [NCNT_W-1:0] nan_cnt_q, nan_cnt_d;

   logic        push_s;
   logic        pop_s;
   logic [3:0]  in_flags_s;
   logic [15:0] wr_res_s;
   logic [3:0]  wr_flags_s;

   assign in_ready_o  = (count_q != FULL_CNT);
   assign out_valid_o = (count_q != {(ADDR_W+1){1'b0}});
   assign push_s      = in_valid_i & in_ready_o;
   assign pop_s       = out_valid_o & out_ready_i;
   assign in_flags_s  = classify(in_res_i);

   // Build the entry that gets written on a push.
   always_comb begin
      wr_res_s   = in_res_i;
      wr_flags_s = in_flags_s;
`ifdef HFMUL_FTZ_EN
      if (in_flags_s[0]) begin
         wr_res_s   = {in_res_i[15], 15'd0};
         wr_flags_s = 4'b0011;
      end else begin
         wr_res_s   = in_res_i;
         wr_flags_s = in_flags_s;
      end
`endif
   end

   // Pointer, occupancy and head-register next state.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_res_d   = out_res_q;
      out_flags_d = out_flags_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // The head register shows the next entry one cycle after it lands; an empty FIFO keeps the last value.
      if (count_d != {(ADDR_W+1){1'b0}}) begin
         if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            out_res_d   = wr_res_s;
            out_flags_d = wr_flags_s;
         end else begin
            out_res_d   = mem_q[rd_ptr_d][19:4];
            out_flags_d = mem_q[rd_ptr_d][3:0];
         end
      end else begin
         out_res_d   = out_res_q;
         out_flags_d = out_flags_q;
      end
   end

   // Sticky flags and saturating NaN counter; a clear discards history but keeps this cycle's push.
   always_comb begin
      sticky_d  = sticky_q;
      nan_cnt_d = nan_cnt_q;
      if (clr_sticky_i) begin
         sticky_d  = push_s ? wr_flags_s : 4'b0000;
         nan_cnt_d = (push_s && wr_flags_s[3]) ? {{(NCNT_W-1){1'b0}}, 1'b1} : {NCNT_W{1'b0}};
      end else if (push_s) begin
         sticky_d = sticky_q | wr_flags_s;
         if (wr_flags_s[3] && (nan_cnt_q != NCNT_MAX)) begin
            nan_cnt_d = nan_cnt_q + 1'b1;
         end else begin
            nan_cnt_d = nan_cnt_q;
         end
      end else begin
         sticky_d  = sticky_q;
         nan_cnt_d = nan_cnt_q;
      end
   end

   // Storage array; contents need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {wr_res_s, wr_flags_s};
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= {ADDR_W{1'b0}};
         rd_ptr_q    <= {ADDR_W{1'b0}};
         count_q     <= {(ADDR_W+1){1'b0}};
         out_res_q   <= 16'd0;
         out_flags_q <= 4'b0000;
         sticky_q    <= 4'b0000;
         nan_cnt_q   <= {NCNT_W{1'b0}};
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_res_q   <= out_res_d;
         out_flags_q <= out_flags_d;
         sticky_q    <= sticky_d;
         nan_cnt_q   <= nan_cnt_d;
      end
   end

   assign out_res_o   = out_res_q;
   assign out_flags_o = out_flags_q;
   assign count_o     = count_q;
   assign sticky_o    = sticky_q;
   assign nan_cnt_o   = nan_cnt_q;

endmodule

// File: tb/tb_hf_mul_result_fifo.sv
// Directed bench for hf_mul_result_fifo: handshake, classification, full/empty edges, sticky, saturation, reset.
module tb_hf_mul_result_fifo;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_res;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_res;
   logic [3:0]  out_flags;
   logic [2:0]  count;
   logic [3:0]  sticky;
   logic        clr_sticky;
   logic [7:0]  nan_cnt;

   int total;
   int bad;

   hf_mul_result_fifo #(.DEPTH(4), .ADDR_W(2), .NCNT_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_res_i     (in_res),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_res_o    (out_res),
      .out_flags_o  (out_flags),
      .count_o      (count),
      .sticky_o     (sticky),
      .clr_sticky_i (clr_sticky),
      .nan_cnt_o    (nan_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_res = 16'h0000; out_ready = 1'b0; clr_sticky = 1'b0;
      #12;
      total++; if (count !== 3'd0)      begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      total++; if (out_res !== 16'h0000 || out_flags !== 4'b0000)
         begin bad++; $display("FAIL reset_out got=%h/%b exp=0000/0000", out_res, out_flags); end
      total++; if (sticky !== 4'b0000 || nan_cnt !== 8'd0)
         begin bad++; $display("FAIL reset_status got=%b/%0d exp=0000/0", sticky, nan_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_res = 16'hC100; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_res !== 16'hC100 || out_flags !== 4'b0000 || count !== 3'd1)
         begin bad++; $display("FAIL single_push got=%b/%h/%b/%0d exp=1/c100/0000/1", out_valid, out_res, out_flags, count); end
      step();
      total++; if (count !== 3'd0 || out_valid !== 1'b0 || out_res !== 16'hC100)
         begin bad++; $display("FAIL single_pop got=%0d/%b/%h exp=0/0/c100", count, out_valid, out_res); end
   endtask

   task automatic test_fill();
      logic [15:0] vals [4];
      vals[0] = 16'h7E00; vals[1] = 16'h7C00; vals[2] = 16'h8000; vals[3] = 16'h0001;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_res = vals[i];
         step();
      end
      in_valid = 1'b0;
      total++; if (count !== 3'd4 || in_ready !== 1'b0)
         begin bad++; $display("FAIL fill_full got=%0d/%b exp=4/0", count, in_ready); end
      total++; if (sticky !== 4'b1111 || nan_cnt !== 8'd1)
         begin bad++; $display("FAIL fill_status got=%b/%0d exp=1111/1", sticky, nan_cnt); end
      total++; if (out_res !== 16'h7E00 || out_flags !== 4'b1000)
         begin bad++; $display("FAIL fill_head got=%h/%b exp=7e00/1000", out_res, out_flags); end
   endtask

   task automatic test_full_pop();
      logic [15:0] evals [4];
      logic [3:0]  eflags [4];
      evals[0] = 16'h7C00; evals[1] = 16'h8000; evals[2] = 16'h0001; evals[3] = 16'h3C00;
      eflags[0] = 4'b0100; eflags[1] = 4'b0010; eflags[2] = 4'b0001; eflags[3] = 4'b0000;
      in_valid = 1'b1; in_res = 16'h3C00; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (count !== 3'd3 || in_ready !== 1'b1)
         begin bad++; $display("FAIL full_pop_no_push got=%0d/%b exp=3/1", count, in_ready); end
      step();
      in_valid = 1'b0;
      total++; if (count !== 3'd4)
         begin bad++; $display("FAIL full_refill got=%0d exp=4", count); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (out_valid !== 1'b1 || out_res !== evals[i] || out_flags !== eflags[i])
            begin bad++; $display("FAIL drain_%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, out_res, out_flags, evals[i], eflags[i]); end
         step();
      end
      total++; if (count !== 3'd0 || out_valid !== 1'b0 || out_res !== 16'h3C00)
         begin bad++; $display("FAIL drain_empty got=%0d/%b/%h exp=0/0/3c00", count, out_valid, out_res); end
   endtask

   task automatic test_sticky_clear();
      in_valid = 1'b1; in_res = 16'h7C01; clr_sticky = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++; if (sticky !== 4'b1000 || nan_cnt !== 8'd1)
         begin bad++; $display("FAIL clr_with_push got=%b/%0d exp=1000/1", sticky, nan_cnt); end
      step();
      clr_sticky = 1'b0;
      total++; if (sticky !== 4'b0000 || nan_cnt !== 8'd0)
         begin bad++; $display("FAIL clr_alone got=%b/%0d exp=0000/0", sticky, nan_cnt); end
   endtask

   task automatic test_saturate_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_res = 16'h7E00;
      for (int i = 0; i < 255; i++) step();
      total++; if (nan_cnt !== 8'hFF)
         begin bad++; $display("FAIL nan_255 got=%h exp=ff", nan_cnt); end
      total++; if (count !== 3'd1 || out_res !== 16'h7E00)
         begin bad++; $display("FAIL push_pop_steady got=%0d/%h exp=1/7e00", count, out_res); end
      step(); step();
      total++; if (nan_cnt !== 8'hFF)
         begin bad++; $display("FAIL nan_sat got=%h exp=ff", nan_cnt); end
      out_ready = 1'b0;
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || nan_cnt !== 8'd0 || out_res !== 16'h0000)
         begin bad++; $display("FAIL async_reset got=%0d/%b/%b/%h/%h exp=0/0/1/00/0000", count, out_valid, in_ready, nan_cnt, out_res); end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_subnormal();
      in_valid = 1'b1; in_res = 16'h8001; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
`ifdef HFMUL_FTZ_EN
      total++; if (out_res !== 16'h8000 || out_flags !== 4'b0011)
         begin bad++; $display("FAIL ftz_sub got=%h/%b exp=8000/0011", out_res, out_flags); end
`else
      total++; if (out_res !== 16'h8001 || out_flags !== 4'b0001)
         begin bad++; $display("FAIL sub_keep got=%h/%b exp=8001/0001", out_res, out_flags); end
`endif
      total++; if (sticky[0] !== 1'b1)
         begin bad++; $display("FAIL sub_sticky got=%b exp=xxx1", sticky); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_sticky_clear();
      test_saturate_reset();
      test_subnormal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
